// File: rtl/audio_dac_sample_ctrl.sv
// Sample sequencer for the 1-bit delta-sigma DAC: clock-enable divider, sample FIFO,
// prime/run/underrun FSM and mute. Define AUDIO_DAC_SOFT_MUTE_EN for the ramped soft mute.
module audio_dac_sample_ctrl #(
   parameter int W          = 16,
   parameter int CLK_DIV    = 4,
   parameter int SAMPLE_DIV = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int GAIN_BITS  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          mute,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [W-1:0]                  s_data,
   output logic                          dac_clk_en,
   output logic [W-1:0]                  dac_in,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   output logic [15:0]                   underrun_cnt,
   output logic [1:0]                    dbg_state
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int SMP_W = $clog2(SAMPLE_DIV);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int PW    = W + GAIN_BITS + 2;

   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [SMP_W-1:0]   SMP_LAST   = SMP_W'(SAMPLE_DIV - 1);
   localparam logic [LVL_W-1:0]   LVL_FULL   = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0]   LVL_HALF   = LVL_W'(FIFO_DEPTH / 2);
   localparam logic [GAIN_BITS:0] GAIN_UNITY = {1'b1, {GAIN_BITS{1'b0}}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRIME = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [W-1:0]     dac_in_q, dac_in_d;
   logic             underrun_q, underrun_d;
   logic [15:0]      ucnt_q, ucnt_d;
   logic [W-1:0]     fifo_mem_q [FIFO_DEPTH];

   logic             sample_tick, fifo_empty, fifo_full, push, pop;
   logic [GAIN_BITS:0] gain_eff;
   logic signed [PW-1:0] prod;
   logic [W-1:0]     scaled;

   // Handshake: a sample transfers on every rising edge where s_valid and s_ready are both
   // high; s_ready depends only on rst_n, enable and FIFO fullness, never on s_valid.
   assign fifo_empty  = (level_q == '0);
   assign fifo_full   = (level_q == LVL_FULL);
   assign s_ready     = rst_n && enable && !fifo_full;
   assign push        = s_valid && s_ready;
   assign dac_clk_en  = (div_cnt_q == DIV_LAST);
   assign sample_tick = (state_q == ST_RUN) && dac_clk_en && (smp_cnt_q == SMP_LAST);
   assign pop         = sample_tick && !fifo_empty;

   // Both builds share the multiply; hard mute just selects a gain of 0 or unity.
   assign prod   = PW'($signed(fifo_mem_q[rd_ptr_q])) * PW'($signed({1'b0, gain_eff}));
   assign scaled = W'(prod >>> GAIN_BITS);

`ifdef AUDIO_DAC_SOFT_MUTE_EN
   logic [GAIN_BITS:0] gain_q, gain_d;

   assign gain_eff = gain_q;

   always_comb begin
      gain_d = gain_q;
      if (state_q == ST_IDLE) begin
         gain_d = mute ? '0 : GAIN_UNITY;
      end else if (sample_tick && enable) begin
         if (mute && gain_q != '0)
            gain_d = gain_q - (GAIN_BITS+1)'(1);
         else if (!mute && gain_q != GAIN_UNITY)
            gain_d = gain_q + (GAIN_BITS+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) gain_q <= GAIN_UNITY;
      else        gain_q <= gain_d;
   end
`else
   assign gain_eff = mute ? '0 : GAIN_UNITY;
`endif

   always_comb begin
      div_cnt_d  = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
      state_d    = state_q;
      smp_cnt_d  = smp_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      dac_in_d   = dac_in_q;
      underrun_d = 1'b0;
      ucnt_d     = ucnt_q;
      if (!enable) begin
         // Stop wins over any tick or push in the same cycle.
         state_d   = ST_IDLE;
         smp_cnt_d = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         dac_in_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         level_d = level_q + LVL_W'(push) - LVL_W'(pop);
         case (state_q)
            ST_IDLE: begin
               state_d   = ST_PRIME;
               smp_cnt_d = '0;
               dac_in_d  = '0;
            end
            ST_PRIME: begin
               smp_cnt_d = '0;
               if (level_q >= LVL_HALF) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (dac_clk_en)
                  smp_cnt_d = (smp_cnt_q == SMP_LAST) ? '0 : smp_cnt_q + SMP_W'(1);
               if (sample_tick) begin
                  if (fifo_empty) begin
                     dac_in_d   = '0;
                     underrun_d = 1'b1;
                     if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
                     state_d    = ST_PRIME;
                  end else begin
                     dac_in_d = scaled;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         div_cnt_q  <= '0;
         smp_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         dac_in_q   <= '0;
         underrun_q <= 1'b0;
         ucnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         smp_cnt_q  <= smp_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         dac_in_q   <= dac_in_d;
         underrun_q <= underrun_d;
         ucnt_q     <= ucnt_d;
      end
   end

   assign dac_in       = dac_in_q;
   assign fifo_level   = level_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = ucnt_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_audio_dac_sample_ctrl.sv
// Bench for audio_dac_sample_ctrl: a behavioural model tracks FIFO contents in exp_q and
// predicts dac_in, level, s_ready and underrun every cycle; directed phases cover the scenarios.
module tb_audio_dac_sample_ctrl;

   localparam int W          = 16;
   localparam int CLK_DIV    = 4;
   localparam int SAMPLE_DIV = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int GAIN_BITS  = 8;
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int GAIN_UNITY = 1 << GAIN_BITS;
   localparam int TICK_CYC   = CLK_DIV * SAMPLE_DIV;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic             mute = 1'b0;
   logic             s_valid = 1'b0;
   logic [W-1:0]     s_data = '0;
   logic             s_ready;
   logic             dac_clk_en;
   logic [W-1:0]     dac_in;
   logic [LVL_W-1:0] fifo_level;
   logic             underrun;
   logic [15:0]      underrun_cnt;
   logic [1:0]       dbg_state;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   bit           m_idle = 1'b1;
   bit           m_run  = 1'b0;
   int           m_cnt  = 0;
   logic [W-1:0] m_dac  = '0;
   bit           m_unr  = 1'b0;
   int           m_ucnt = 0;
   int           m_gain = GAIN_UNITY;
   int           tick_n = 0;

   audio_dac_sample_ctrl #(
      .W(W), .CLK_DIV(CLK_DIV), .SAMPLE_DIV(SAMPLE_DIV),
      .FIFO_DEPTH(FIFO_DEPTH), .GAIN_BITS(GAIN_BITS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mute(mute),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .dac_clk_en(dac_clk_en), .dac_in(dac_in), .fifo_level(fifo_level),
      .underrun(underrun), .underrun_cnt(underrun_cnt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] scale(input logic [W-1:0] x, input int gain);
      longint p;
      p = longint'($signed(x)) * longint'(gain);
      return W'(p >>> GAIN_BITS);
   endfunction

   // Scoreboard: compare current outputs, then advance the model for the coming edge.
   always @(negedge clk) begin : mon
      logic         m_ready;
      bit           tick;
      logic [W-1:0] head;
      int           g;
      m_ready = rst_n && enable && (exp_q.size() < FIFO_DEPTH);
      check("dac_in", dac_in, m_dac);
      check("fifo_level", fifo_level, exp_q.size());
      check("s_ready", s_ready, m_ready);
      check("underrun", underrun, m_unr);
      check("underrun_cnt", underrun_cnt, m_ucnt);
      if (!rst_n) begin
         exp_q.delete();
         m_idle = 1'b1; m_run = 1'b0; m_cnt = 0; m_dac = '0;
         m_unr = 1'b0; m_ucnt = 0; m_gain = GAIN_UNITY;
      end else begin
         m_unr = 1'b0;
         if (m_idle) m_gain = mute ? 0 : GAIN_UNITY;
         if (!enable) begin
            exp_q.delete();
            m_idle = 1'b1; m_run = 1'b0; m_cnt = 0; m_dac = '0;
         end else begin
            tick = 1'b0;
            if (m_idle) m_idle = 1'b0;
            else if (!m_run) begin
               if (exp_q.size() >= FIFO_DEPTH / 2) m_run = 1'b1;
            end else if (dac_clk_en) begin
               if (m_cnt == SAMPLE_DIV - 1) begin tick = 1'b1; m_cnt = 0; end
               else m_cnt++;
            end
            if (tick) begin
               tick_n++;
`ifdef AUDIO_DAC_SOFT_MUTE_EN
               g = m_gain;
               if (mute && m_gain > 0) m_gain--;
               else if (!mute && m_gain < GAIN_UNITY) m_gain++;
`else
               g = mute ? 0 : GAIN_UNITY;
`endif
               if (exp_q.size() == 0) begin
                  m_dac = '0; m_unr = 1'b1; m_run = 1'b0;
                  if (m_ucnt < 16'hFFFF) m_ucnt++;
               end else begin
                  head  = exp_q.pop_front();
                  m_dac = scale(head, g);
               end
            end
            if (m_ready && s_valid) exp_q.push_back(s_data);
         end
      end
   end

   task automatic push_sample(input logic [W-1:0] d);
      bit done = 1'b0;
      int n = 0;
      s_data  = d;
      s_valid = 1'b1;
      while (!done && n < 200) begin
         @(negedge clk);
         done = s_ready;
         @(posedge clk); #1;
         n++;
      end
      s_valid = 1'b0;
      check("push_accepted", done, 1);
   endtask

   // Returns on the edge where the n-th further sample tick updates dac_in.
   task automatic wait_ticks(input int n);
      int target = tick_n + n;
      int budget = 0;
      while (tick_n < target && budget < (n + 2) * TICK_CYC) begin
         @(posedge clk);
         budget++;
      end
      check("tick_reached", tick_n >= target, 1);
   endtask

   task automatic wait_level(input int lvl);
      int budget = 0;
      while (fifo_level != LVL_W'(lvl) && budget < 4 * TICK_CYC) begin
         @(negedge clk);
         budget++;
      end
      check("level_reached", fifo_level, lvl);
   endtask

   initial begin : stim
      int pulse_at[$];
      bit acc;
      // T1 reset and divider
      repeat (10) begin
         @(negedge clk);
         check("rst_clk_en", dac_clk_en, 0);
      end
      check("rst_dac_in", dac_in, 0);
      check("rst_ucnt", underrun_cnt, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (dac_clk_en) pulse_at.push_back(c);
      end
      check("pulse_count", pulse_at.size(), 3);
      for (int i = 1; i < pulse_at.size(); i++)
         check("pulse_gap", pulse_at[i] - pulse_at[i-1], CLK_DIV);

      // T2 prime and play
      @(posedge clk); #1 enable = 1'b1;
      push_sample(16'h1000);
      push_sample(16'h2000);
      wait_ticks(1); #1 check("t2_first", dac_in, 16'h1000);
      wait_ticks(1); #1 check("t2_second", dac_in, 16'h2000);

      // T3 underrun
      wait_ticks(1); #1;
      check("t3_dac", dac_in, 0);
      check("t3_pulse", underrun, 1);
      check("t3_cnt", underrun_cnt, 1);
      @(posedge clk); #1 check("t3_pulse_end", underrun, 0);

      // T4 continuous valid, then random valid
      s_data  = 16'($urandom_range(0, 65535));
      s_valid = 1'b1;
      for (int c = 0; c < 8 * TICK_CYC; c++) begin
         @(negedge clk);
         acc = s_ready && s_valid;
         @(posedge clk); #1;
         if (acc) s_data = 16'($urandom_range(0, 65535));
         if (c >= 4 * TICK_CYC) s_valid = ($urandom_range(0, 2) != 0);
      end

      // T5 stop mid-play at level 3
      s_valid = 1'b1;
      wait_level(FIFO_DEPTH);
      @(posedge clk); #1 s_valid = 1'b0;
      wait_level(FIFO_DEPTH - 1);
      @(posedge clk); #1 enable = 1'b0;
      @(posedge clk); #1;
      check("t5_level", fifo_level, 0);
      check("t5_dac", dac_in, 0);
      check("t5_ready", s_ready, 0);
      enable = 1'b1;
      repeat (3 * TICK_CYC) @(posedge clk);
      #1 check("t5_unprimed_dac", dac_in, 0);

      // T6 mute
      s_data  = 16'h4000;
      s_valid = 1'b1;
      wait_ticks(2); #1 check("t6_play", dac_in, 16'h4000);
      mute = 1'b1;
`ifdef AUDIO_DAC_SOFT_MUTE_EN
      wait_ticks(1); #1 check("t6_ramp0", dac_in, 16'h4000);
      wait_ticks(1); #1 check("t6_ramp1", dac_in, 16'h3FC0);
      wait_ticks(1); #1 check("t6_ramp2", dac_in, 16'h3F80);
      wait_ticks(254); #1 check("t6_silent", dac_in, 0);
      mute = 1'b0;
      wait_ticks(257); #1 check("t6_unmuted", dac_in, 16'h4000);
`else
      wait_ticks(1); #1 check("t6_muted", dac_in, 0);
      mute = 1'b0;
      wait_ticks(1); #1 check("t6_unmuted", dac_in, 16'h4000);
`endif
      s_valid = 1'b0;
      enable  = 1'b0;
      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
